iob_ibex_axi_port: RTL and testbench
====================================

// Module: iob_ibex_axi_port
// PURPOSE
// - Registered bridge between one Ibex memory port (instr or data) and an AXI4 manager interface.
// - Supports up to MAX_OUTST outstanding transactions, with AW and W handshakes completed independently.
// - Responses to Ibex stay in order; responses are never dropped.
// - Two instances (WRITE_EN=0 for instr, WRITE_EN=1 for data) replace the combinational Ibex-to-AXI glue in the CPU wrapper.
// PARAMETERS
// - AXI_ID_W    1   width of AXI ID fields; all IDs are driven with AXI_ID.
// - AXI_ID      0   constant ID for AWID/ARID.
// - AXI_ADDR_W  32  AXI byte-address width.
// - AXI_LEN_W   8   width of AWLEN/ARLEN.
// - IBEX_ADDR_W 32  Ibex byte-address width; the port carries the word address [IBEX_ADDR_W-3:0].
// - MAX_OUTST   2   maximum accepted-but-unanswered requests (1..15).
// - WRITE_EN    1   1 = AW/W/B channels are live; 0 = write path is tied off and writes are never granted.
// PORTS
// - clk_i          in   1    clock
// - cke_i          in   1    clock enable; all state holds when 0
// - arst_n_i       in   1    asynchronous reset, active low
// - req_i          in   1    Ibex request
// - we_i           in   1    1 = write (ignored when WRITE_EN=0)
// - be_i           in   4    byte enables
// - addr_i         in   IBEX_ADDR_W-2  word address
// - wdata_i        in   32   write data
// - gnt_o          out  1    request accepted this cycle
// - rvalid_o       out  1    response valid, one cycle per request
// - rdata_o        out  32   read data (0 on write responses)
// - err_o          out  1    bus error, qualified by rvalid_o
// - axi_aw*/axi_w*/axi_b*  AXI4 write channels (awid/addr/len/size/burst/lock/cache/prot/qos/valid/ready; wdata/wstrb/wlast/valid/ready; bid/bresp/bvalid/bready)
// - axi_ar*/axi_r*         AXI4 read channels (arid/addr/len/size/burst/lock/cache/prot/qos/valid/ready; rid/rdata/rresp/rlast/rvalid/rready)
// BEHAVIOUR
// - Clock and reset: one clock, clk_i. arst_n_i is asynchronous and active low.
//   All registers clear on reset; all outputs reset to 0 except bready and rready (tied 1).
// - Holding register: one entry. gnt_o = req_i & hold_empty & (cnt < MAX_OUTST) & ~dir_block.
//   On gnt, the register captures addr, we, be and wdata; the same cycle cnt increments and dir <= we.
// - dir_block: set when cnt != 0 and we_i != dir.
//   A read/write direction switch waits until cnt == 0. This keeps B vs R ordering with a single ID.
// - Write issue (cycle after gnt)
//   - awvalid and wvalid are both asserted from the holding register.
//   - Per-channel done flags are set on awready and wready respectively; each valid drops once its own handshake completes.
//   - The holding register empties when both flags are set, including on the same cycle.
//   - Min grant-to-address-handshake latency: 1 cycle.
// - Read issue: arvalid is asserted from the holding register and held until arready. The holding register empties on the handshake.
// - Fixed AXI fields:
//   - awaddr/araddr = {addr,2'b00}, zero-extended to AXI_ADDR_W.
//   - size = 3'b010, len = 0, burst = INCR, wlast = 1, wstrb = be.
//   - lock, cache, prot and qos = 0.
// - Valid/data stability: once asserted, AXI valid and data do not change until the handshake. Ibex may drop req_i freely; nothing is captured without gnt.
// - Response path
//   - rvalid_o = rvalid | bvalid (one-hot by construction).
//   - err_o = resp != OKAY.
//   - rdata_o = R data.
//   - cnt decrements on each response. The increment and decrement may coincide; cnt is then unchanged.
// - Boundary cases
//   - cnt == MAX_OUTST: gnt_o = 0.
//   - A response with cnt == 0 (protocol violation) is ignored; cnt saturates at 0 and, in simulation, an assertion fires.
//   - WRITE_EN=0: requests with we_i=1 are never granted, and aw/w valids are tied 0.
//   - Reset mid-transaction: AXI valids drop immediately; the interconnect is reset together with the bridge.
// CONFIGURATION
// - Macro IOB_IBEX_AXI_RESP_REG_EN.
// - Defined: rvalid_o, rdata_o and err_o are registered, adding +1 cycle response latency.
//   cnt still decrements on the AXI handshake; the register accepts one response per cycle with no backpressure.
// - Undefined: the response path is combinational from R/B to Ibex.
// STRUCTURE
// - Package iob_ibex_axi_pkg holds:
//   - AXI_BURST_INCR, AXI_SIZE_4B and AXI_RESP_OKAY constants;
//   - hold_t (addr, we, be, wdata) struct;
//   - outstanding-counter width function clog2(MAX_OUTST+1).
// - Sub-module iob_ibex_axi_outst_cnt: up/down counter with full/empty flags and simultaneous inc/dec.
// - Everything else stays in the top module.
// TESTING
// 1. Read, arready=1, R 2 cycles later with data 0xDEADBEEF, resp OKAY -> gnt, one rvalid_o, rdata_o = 0xDEADBEEF, err_o = 0.
// 2. Write addr 0x100, be 4'b0011, awready delayed 3 cycles, wready=1 -> awaddr 0x400, wstrb 4'b0011; wvalid drops after 1 cycle, awvalid after 3; one rvalid_o after B.
// 3. MAX_OUTST=2, four back-to-back reads, R withheld -> exactly 2 grants; grants resume one per returned R; 4 rvalid_o in order.
// 4. Write outstanding, then a read request -> gnt_o = 0 until B returns, then read granted.
// 5. rresp = SLVERR on a read; bresp = DECERR on a write -> err_o = 1 with each rvalid_o.
// 6. arst_n_i low while arvalid is pending -> arvalid = 0 immediately; cnt = 0; after release the first read is granted normally.

Source files
------------

// File: rtl/iob_ibex_axi_pkg.sv
// iob_ibex_axi_pkg: shared AXI constants, holding-register type and counter sizing
package iob_ibex_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Word-address width carried by the holding register (32-bit Ibex byte address)
    localparam int HOLD_ADDR_W = 30;

    typedef struct packed {
        logic [HOLD_ADDR_W-1:0] addr;
        logic                   we;
        logic [3:0]             be;
        logic [31:0]            wdata;
    } hold_t;

    // Bits needed to count 0..max_outst
    function automatic int cnt_w(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

endpackage

// File: rtl/iob_ibex_axi_port_if.sv
// iob_ibex_axi_port_if: AXI4 single-ID manager bus
// master modport: driven by the bridge (aw/w/ar payload + valids, bready, rready)
// slave modport:  driven by the interconnect (readies, b and r responses)
interface iob_ibex_axi_port_if #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_LEN_W  = 8
);
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [AXI_LEN_W-1:0]  awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [AXI_LEN_W-1:0]  arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/iob_ibex_axi_outst_cnt.sv
// iob_ibex_axi_outst_cnt: outstanding-request up/down counter
// Ports: clk, arst_n (async, active low), cke (hold when 0),
//        inc/dec (may coincide), full (cnt == MAX), empty (cnt == 0)
module iob_ibex_axi_outst_cnt import iob_ibex_axi_pkg::*; #(
    parameter int MAX = 2,
    parameter int W   = cnt_w(MAX)
) (
    input  logic clk,
    input  logic arst_n,
    input  logic cke,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [W-1:0] cnt;
    logic         dec_ok;

    // A response with nothing outstanding is dropped so the count saturates at 0
    assign dec_ok = dec && (cnt != '0);
    assign full   = cnt == W'(MAX);
    assign empty  = cnt == '0;

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n)
            cnt <= '0;
        else if (cke)
            cnt <= cnt + W'(inc) - W'(dec_ok);

    a_no_spurious_resp: assert property (@(posedge clk) disable iff (!arst_n) !(cke && dec && empty));

endmodule

// File: rtl/iob_ibex_axi_port.sv
// iob_ibex_axi_port: registered bridge from one Ibex memory port to an AXI4 manager
// Ports: clk_i, cke_i (global hold), arst_n_i (async, active low);
//        Ibex side req_i/we_i/be_i/addr_i/wdata_i -> gnt_o/rvalid_o/rdata_o/err_o;
//        axi: AXI4 manager bus (iob_ibex_axi_port_if.master)
// Option: define IOB_IBEX_AXI_RESP_REG_EN to register rvalid_o/rdata_o/err_o (+1 cycle)
module iob_ibex_axi_port import iob_ibex_axi_pkg::*; #(
    parameter int AXI_ID_W    = 1,
    parameter int AXI_ID      = 0,
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_LEN_W   = 8,
    parameter int IBEX_ADDR_W = 32,
    parameter int MAX_OUTST   = 2,
    parameter int WRITE_EN    = 1
) (
    input  logic                   clk_i,
    input  logic                   cke_i,
    input  logic                   arst_n_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [3:0]             be_i,
    input  logic [IBEX_ADDR_W-3:0] addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   err_o,
    iob_ibex_axi_port_if.master    axi
);

    localparam logic WR = WRITE_EN != 0;

    hold_t       hold;
    logic        hold_v, dir, aw_done, w_done;
    logic        full, empty, dir_block, gnt;
    logic        aw_hs, w_hs, ar_hs, wr_done, issue_done;
    logic        resp_v, resp_err;
    logic [31:0] resp_data;
    logic        unused;

    // With a single ID, B and R may only be reordered across directions, so a
    // direction change waits for every outstanding response
    assign dir_block = !empty && (we_i != dir);
    assign gnt       = arst_n_i && cke_i && req_i && !hold_v && !full && !dir_block && (WR || !we_i);
    assign gnt_o     = gnt;

    assign axi.awvalid = WR && hold_v && hold.we && !aw_done;
    assign axi.wvalid  = WR && hold_v && hold.we && !w_done;
    assign axi.arvalid = hold_v && !hold.we;
    assign aw_hs       = axi.awvalid && axi.awready;
    assign w_hs        = axi.wvalid && axi.wready;
    assign ar_hs       = axi.arvalid && axi.arready;
    assign wr_done     = (aw_done || aw_hs) && (w_done || w_hs);
    assign issue_done  = hold.we ? wr_done : ar_hs;

    assign axi.awid    = AXI_ID_W'(AXI_ID);
    assign axi.awaddr  = AXI_ADDR_W'({hold.addr, 2'b00});
    assign axi.awlen   = '0;
    assign axi.awsize  = AXI_SIZE_4B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = '0;
    assign axi.awprot  = '0;
    assign axi.awqos   = '0;
    assign axi.wdata   = hold.wdata;
    assign axi.wstrb   = hold.be;
    assign axi.wlast   = 1'b1;
    assign axi.bready  = 1'b1;
    assign axi.arid    = AXI_ID_W'(AXI_ID);
    assign axi.araddr  = AXI_ADDR_W'({hold.addr, 2'b00});
    assign axi.arlen   = '0;
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.arqos   = '0;
    assign axi.rready  = 1'b1;

    // Single ID and single-beat bursts: these carry no information
    assign unused = ^{axi.bid, axi.rid, axi.rlast};

    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) begin
            hold    <= '0;
            hold_v  <= 1'b0;
            dir     <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (cke_i) begin
            if (gnt) begin
                hold   <= '{addr: HOLD_ADDR_W'(addr_i), we: WR && we_i, be: be_i, wdata: wdata_i};
                hold_v <= 1'b1;
                dir    <= WR && we_i;
            end else if (hold_v && issue_done) begin
                hold_v <= 1'b0;
            end
            // AW and W complete independently; both flags clear once the pair is done
            aw_done <= hold_v && hold.we && !wr_done && (aw_done || aw_hs);
            w_done  <= hold_v && hold.we && !wr_done && (w_done || w_hs);
        end

    iob_ibex_axi_outst_cnt #(.MAX(MAX_OUTST)) u_cnt (
        .clk    (clk_i),
        .arst_n (arst_n_i),
        .cke    (cke_i),
        .inc    (gnt),
        .dec    (resp_v),
        .full   (full),
        .empty  (empty)
    );

    // R and B are never valid together because directions are never mixed
    assign resp_v    = axi.rvalid || (WR && axi.bvalid);
    assign resp_data = axi.rvalid ? axi.rdata : '0;
    assign resp_err  = axi.rvalid ? (axi.rresp != AXI_RESP_OKAY)
                                  : (WR && axi.bvalid && (axi.bresp != AXI_RESP_OKAY));

`ifdef IOB_IBEX_AXI_RESP_REG_EN
    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else if (cke_i) begin
            rvalid_o <= resp_v;
            rdata_o  <= resp_data;
            err_o    <= resp_err;
        end
`else
    assign rvalid_o = resp_v;
    assign rdata_o  = resp_data;
    assign err_o    = resp_err;
`endif

endmodule

// File: tb/tb_iob_ibex_axi_port.sv
// tb_iob_ibex_axi_port: randomized self-checking bench with a queue-based reference model
module tb_iob_ibex_axi_port;

    localparam int MAX = 2;

    typedef struct packed {
        logic [29:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        cke = 1'b1;
    logic        arst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    iob_ibex_axi_port_if #(.AXI_ID_W(1), .AXI_ADDR_W(32), .AXI_LEN_W(8)) axi ();

    iob_ibex_axi_port #(.MAX_OUTST(MAX), .WRITE_EN(1)) dut (
        .clk_i    (clk),
        .cke_i    (cke),
        .arst_n_i (arst_n),
        .req_i    (req),
        .we_i     (we),
        .be_i     (be),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .axi      (axi)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int n_gnt = 0, n_gd = 0, n_rv = 0, n_err = 0;

    // stimulus applied by step() at the next falling edge
    logic        s_req = 0, s_we = 0, s_awr = 1, s_wr = 1, s_arr = 1;
    logic [3:0]  s_be = 4'hf;
    logic [29:0] s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic        resp_en = 1;
    int          resp_pct = 100;

    // reference model state
    req_t        iss_q[$];
    logic [29:0] rd_q[$], wr_q[$];
    logic [32:0] rsp_q[$];
    int          cnt_m = 0;
    logic        dir_m = 0, aw_seen = 0, w_seen = 0;
    logic [29:0] aw_a = '0;

    function automatic logic [31:0] rfun(input logic [29:0] a);
        return ({a, 2'b00} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction
    function automatic logic rerr(input logic [29:0] a);
        return (a % 5) == 0;
    endfunction
    function automatic logic werr(input logic [29:0] a);
        return (a % 7) == 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        iss_q.delete(); rd_q.delete(); wr_q.delete(); rsp_q.delete();
        cnt_m = 0; dir_m = 0; aw_seen = 0; w_seen = 0;
    endtask

    task automatic step();
        logic eg, ea, ew, er, gr, gb;
        logic [29:0] ra, wa, cap_aw, cap_ar;
        req_t fr;
        @(negedge clk);
        req = s_req; we = s_we; be = s_be; addr = s_addr; wdata = s_wdata;
        axi.awready = s_awr; axi.wready = s_wr; axi.arready = s_arr;
        ra = rd_q.size() != 0 ? rd_q[0] : '0;
        wa = wr_q.size() != 0 ? wr_q[0] : '0;
        gr = resp_en && rd_q.size() != 0 && $urandom_range(99) < resp_pct;
        gb = resp_en && !gr && wr_q.size() != 0 && $urandom_range(99) < resp_pct;
        axi.rvalid = gr;
        axi.rdata  = gr ? rfun(ra) : $urandom;
        axi.rresp  = (gr && rerr(ra)) ? 2'b10 : 2'b00;
        axi.bvalid = gb;
        axi.bresp  = (gb && werr(wa)) ? 2'b11 : 2'b00;
        #1;
        fr = iss_q.size() != 0 ? iss_q[0] : '0;
        eg = s_req && iss_q.size() == 0 && cnt_m < MAX && !(cnt_m != 0 && s_we != dir_m);
        ea = iss_q.size() != 0 && fr.we && !aw_seen;
        ew = iss_q.size() != 0 && fr.we && !w_seen;
        er = iss_q.size() != 0 && !fr.we;
        check("gnt", gnt, eg);
        check("awvalid", axi.awvalid, ea);
        check("wvalid", axi.wvalid, ew);
        check("arvalid", axi.arvalid, er);
        if (ea) begin
            check("awaddr", axi.awaddr, {fr.addr, 2'b00});
            check("aw_fixed", {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot, axi.awqos},
                  {1'b0, 8'h0, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0});
        end
        if (ew) begin
            check("wdata", axi.wdata, fr.wdata);
            check("wstrb", axi.wstrb, fr.be);
            check("wlast", axi.wlast, 1'b1);
        end
        if (er) begin
            check("araddr", axi.araddr, {fr.addr, 2'b00});
            check("ar_fixed", {axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot, axi.arqos},
                  {1'b0, 8'h0, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0});
        end
        check("rvalid_o", rvalid, gr || gb);
        if (gr || gb) begin
            check("rsp_pending", rsp_q.size() != 0, 1'b1);
            if (rsp_q.size() != 0) begin
                check("rdata_o", rdata, rsp_q[0][31:0]);
                check("err_o", err, rsp_q[0][32]);
            end
        end
        if (gnt) n_gd++;
        if (rvalid) n_rv++;
        if (rvalid && err) n_err++;
        cap_aw = axi.awaddr[31:2];
        cap_ar = axi.araddr[31:2];
        @(posedge clk);
        if (gr) void'(rd_q.pop_front());
        if (gb) void'(wr_q.pop_front());
        if ((gr || gb) && rsp_q.size() != 0) void'(rsp_q.pop_front());
        if ((gr || gb) && cnt_m > 0) cnt_m--;
        if (er && s_arr) begin
            rd_q.push_back(cap_ar);
            void'(iss_q.pop_front());
        end else if (ea || ew) begin
            if (ea && s_awr) begin aw_seen = 1; aw_a = cap_aw; end
            if (ew && s_wr) w_seen = 1;
            if (aw_seen && w_seen) begin
                wr_q.push_back(aw_a);
                void'(iss_q.pop_front());
                aw_seen = 0; w_seen = 0;
            end
        end
        if (eg) begin
            iss_q.push_back('{addr: s_addr, we: s_we, be: s_be, wdata: s_wdata});
            rsp_q.push_back(s_we ? {werr(s_addr), 32'h0} : {rerr(s_addr), rfun(s_addr)});
            cnt_m++;
            dir_m = s_we;
            n_gnt++;
        end
    endtask

    initial begin
        int g0, r0, e0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
        axi.rvalid = 0; axi.rresp = 0; axi.rid = 0; axi.rdata = 0; axi.rlast = 1;
        req = 1;
        #3;
        check("rst_gnt", gnt, 0);
        check("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, rvalid}, 4'b0);
        check("rst_readies", {axi.bready, axi.rready}, 2'b11);
        req = 0;
        repeat (2) @(negedge clk);
        arst_n = 1;

        // single read
        g0 = n_gd; r0 = n_rv;
        s_req = 1; s_we = 0; s_addr = 30'h40; step();
        s_req = 0; repeat (4) step();
        check("t1_gnts", n_gd - g0, 1);
        check("t1_rvalids", n_rv - r0, 1);

        // write with AW held off three cycles
        r0 = n_rv;
        s_awr = 0; s_req = 1; s_we = 1; s_addr = 30'h100; s_be = 4'b0011; s_wdata = 32'hCAFE_F00D; step();
        s_req = 0; repeat (3) step();
        s_awr = 1; repeat (4) step();
        check("t2_rvalids", n_rv - r0, 1);

        // outstanding limit with R withheld
        g0 = n_gd; r0 = n_rv;
        resp_en = 0; s_we = 0; s_req = 1;
        for (int i = 0; i < 8; i++) begin s_addr = 30'($urandom); step(); end
        check("t3_cap_gnts", n_gd - g0, MAX);
        resp_en = 1;
        for (int i = 0; i < 20 && n_gd - g0 < 4; i++) begin s_addr = 30'($urandom); step(); end
        s_req = 0; repeat (6) step();
        check("t3_gnts", n_gd - g0, 4);
        check("t3_rvalids", n_rv - r0, 4);

        // read blocked behind outstanding write
        g0 = n_gd;
        resp_en = 0; s_req = 1; s_we = 1; s_addr = 30'h77; step();
        s_req = 0; repeat (3) step();
        s_req = 1; s_we = 0; s_addr = 30'h78; repeat (4) step();
        check("t4_blocked", n_gd - g0, 1);
        resp_en = 1;
        for (int i = 0; i < 10 && n_gd - g0 < 2; i++) step();
        check("t4_read_gnt", n_gd - g0, 2);
        s_req = 0; repeat (4) step();

        // error responses on both directions
        e0 = n_err;
        s_req = 1; s_we = 0; s_addr = 30'd35; step();
        s_req = 0; repeat (4) step();
        s_req = 1; s_we = 1; s_addr = 30'd35; step();
        s_req = 0; repeat (4) step();
        check("t5_errs", n_err - e0, 2);

        // randomized traffic
        resp_pct = 60;
        for (int i = 0; i < 1500; i++) begin
            s_req = $urandom_range(3) != 0;
            s_we = $urandom_range(1) != 0;
            s_addr = ($urandom_range(1) != 0) ? 30'($urandom) : 30'($urandom_range(63));
            s_be = 4'($urandom);
            s_wdata = $urandom;
            s_awr = $urandom_range(9) < 7;
            s_wr = $urandom_range(9) < 7;
            s_arr = $urandom_range(9) < 7;
            step();
        end
        s_req = 0; s_awr = 1; s_wr = 1; s_arr = 1; resp_pct = 100;
        repeat (20) step();
        check("drain_rsp", n_rv, n_gnt);

        // reset while a read address is pending
        s_arr = 0; s_req = 1; s_we = 0; s_addr = 30'h55; step();
        s_req = 0; step();
        @(negedge clk);
        arst_n = 0; req = 1;
        #1;
        check("t6_arvalid", axi.arvalid, 0);
        check("t6_gnt_in_rst", gnt, 0);
        req = 0;
        model_clear();
        repeat (2) @(negedge clk);
        arst_n = 1;
        g0 = n_gd; r0 = n_rv; s_arr = 1;
        s_req = 1; s_addr = 30'h56; step();
        s_req = 0; repeat (4) step();
        check("t6_gnts", n_gd - g0, 1);
        check("t6_rvalids", n_rv - r0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
